// File: rtl/mfm_byte_assembler_pkg.sv
// Shared types and constants for the MFM read-path byte assembler.
// Also intended for the future write-path serialiser.
package mfm_byte_assembler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_READING = 2'd2
  } state_e;

  typedef enum logic {
    PH_CLOCK = 1'b0,
    PH_DATA  = 1'b1
  } phase_e;

  localparam logic [15:0] MFM_SYNC_A1 = 16'h4489;
  localparam logic [15:0] MFM_SYNC_C2 = 16'h5224;

endpackage

// File: rtl/mfm_byte_assembler_if.sv
// Byte stream from the assembler to the acquisition RAM writer (valid/ready).
interface mfm_byte_assembler_if;
  logic [7:0] DATA_OUT;
  logic       DATA_VALID;
  logic       DATA_READY;

  modport master (output DATA_OUT, output DATA_VALID, input DATA_READY);
  modport slave  (input DATA_OUT, input DATA_VALID, output DATA_READY);
endinterface

// File: rtl/mfm_byte_fifo.sv
// Small synchronous byte FIFO with registered head output and flush.
// A push into a full FIFO is dropped even when a pop happens in the same cycle.
module mfm_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign dout    = dout_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    dout_d   = dout_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (pop_ok) begin
      // head moves to the next stored entry, or to the byte arriving now
      if (count_q > (AW+1)'(1)) dout_d = mem_q[rd_ptr_q + AW'(1)];
      else if (push_ok)         dout_d = din;
    end else if (push_ok && empty) begin
      dout_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/mfm_byte_assembler.sv
// Packs MFM data bits (clock bits discarded) into bytes after a sync-word match
// and hands them to the RAM writer through a small FIFO.
//
// state      | meaning
// ST_IDLE    | strobes ignored, waiting for ARM
// ST_ARMED   | waiting for rising edge of registered sync detect
// ST_READING | decoding cells into bytes until BYTE_COUNT reached or ABORT
module mfm_byte_assembler
  import mfm_byte_assembler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int COUNT_W    = 16
) (
  input  logic               CLK_PLL32MHZ,
  input  logic               RESET_N,
  input  logic               ARM,
  input  logic               ABORT,
  input  logic [COUNT_W-1:0] BYTE_COUNT,
  input  logic               MFM_BIT_STROBE,
  input  logic               MFM_BIT,
  input  logic               SYNC_WORD_DETECTED,
  output logic               BUSY,
  output logic               DONE,
  output logic               OVERRUN,
  output logic               MFM_ERROR,
  mfm_byte_assembler_if.master out_if
);
  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [6:0]         sr_q, sr_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic               prev_cell_q, prev_cell_d;
  logic               done_q, done_d, ovr_q, ovr_d, err_q, err_d;
  logic               sync_q, sync_prev_q, sync_rise;
  logic               push_q, push_d;
  logic [7:0]         push_byte_q, push_byte_d;
  logic               flush, fifo_full, fifo_empty, fifo_pop;

  assign sync_rise = sync_q & ~sync_prev_q;
  assign cnt_inc   = cnt_q + COUNT_W'(1);
  assign fifo_pop  = out_if.DATA_READY & ~fifo_empty;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    cnt_d       = cnt_q;
    prev_cell_d = prev_cell_q;
    done_d      = done_q;
    ovr_d       = ovr_q;
    err_d       = err_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    flush       = 1'b0;
    if (ABORT) begin
      state_d = ST_IDLE;
      flush   = 1'b1;
    end else if (ARM) begin
      state_d = ST_ARMED;
      flush   = 1'b1;
      done_d  = 1'b0;
      ovr_d   = 1'b0;
      err_d   = 1'b0;
      cnt_d   = '0;
    end else if ((state_q != ST_IDLE) && sync_rise) begin
      // first sync starts reading; a later one re-aligns and drops the partial byte
      state_d     = ST_READING;
      phase_d     = PH_CLOCK;
      sr_d        = '0;
      bit_cnt_d   = '0;
      prev_cell_d = 1'b0;
    end else if ((state_q == ST_READING) && MFM_BIT_STROBE) begin
      prev_cell_d = MFM_BIT;
      if (MFM_BIT && prev_cell_q) err_d = 1'b1;
      phase_d = (phase_q == PH_CLOCK) ? PH_DATA : PH_CLOCK;
      if (phase_q == PH_DATA) begin
        sr_d      = {sr_q[5:0], MFM_BIT};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          push_d      = 1'b1;
          push_byte_d = {sr_q, MFM_BIT};
          cnt_d       = cnt_inc;
          if ((BYTE_COUNT != '0) && (cnt_inc == BYTE_COUNT)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
    end
    if (push_q && fifo_full && !flush) ovr_d = 1'b1;
  end

  always_ff @(posedge CLK_PLL32MHZ) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_CLOCK;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      cnt_q       <= '0;
      prev_cell_q <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      err_q       <= 1'b0;
      sync_q      <= 1'b0;
      sync_prev_q <= 1'b0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      cnt_q       <= cnt_d;
      prev_cell_q <= prev_cell_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      err_q       <= err_d;
      sync_q      <= SYNC_WORD_DETECTED;
      sync_prev_q <= sync_q;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
    end
  end

  mfm_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK_PLL32MHZ),
    .rst_n (RESET_N),
    .flush (flush),
    .push  (push_q),
    .din   (push_byte_q),
    .pop   (fifo_pop),
    .dout  (out_if.DATA_OUT),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_if.DATA_VALID = ~fifo_empty;
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = done_q;
  assign OVERRUN   = ovr_q;
  assign MFM_ERROR = err_q;
endmodule

// File: tb/tb_mfm_byte_assembler.sv
// Directed bench for mfm_byte_assembler: table of single-byte cell patterns
// plus hand-written multi-byte, overrun, re-align and reset sequences.
module tb_mfm_byte_assembler;
  import mfm_byte_assembler_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, arm, abort, strobe, mbit, sync;
  logic [15:0] byte_count;
  logic        busy, done, overrun, mfm_err;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  got_q[$];

  mfm_byte_assembler_if bus ();

  mfm_byte_assembler #(.FIFO_DEPTH(4), .COUNT_W(16)) dut (
    .CLK_PLL32MHZ       (clk),
    .RESET_N            (rst_n),
    .ARM                (arm),
    .ABORT              (abort),
    .BYTE_COUNT         (byte_count),
    .MFM_BIT_STROBE     (strobe),
    .MFM_BIT            (mbit),
    .SYNC_WORD_DETECTED (sync),
    .BUSY               (busy),
    .DONE               (done),
    .OVERRUN            (overrun),
    .MFM_ERROR          (mfm_err),
    .out_if             (bus.master)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && bus.DATA_VALID && bus.DATA_READY) got_q.push_back(bus.DATA_OUT);

  typedef struct {
    logic [15:0] cells;
    logic [7:0]  exp_byte;
    logic        exp_err;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] enc(input logic [7:0] d, input logic prev);
    logic [15:0] r;
    logic        p;
    p = prev;
    for (int i = 7; i >= 0; i--) begin
      r[2*i+1] = ~(p | d[i]);
      r[2*i]   = d[i];
      p        = d[i];
    end
    return r;
  endfunction

  task automatic send_cells(input logic [15:0] c, input int n);
    for (int k = 15; k >= 16 - n; k--) begin
      strobe = 1'b1;
      mbit   = c[k];
      tick();
      strobe = 1'b0;
      mbit   = 1'b0;
      tick();
    end
  endtask

  task automatic do_arm(input logic [15:0] cnt);
    byte_count = cnt;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic sync_pulse();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_bytes(input string name, input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) tick();
    chk(name, got_q.size(), n);
  endtask

  initial begin
    vecs[0] = '{16'h5554, 8'hFE, 1'b0};
    vecs[1] = '{16'h4489, 8'hA1, 1'b0};
    vecs[2] = '{16'hAAAA, 8'h00, 1'b0};
    vecs[3] = '{16'h5555, 8'hFF, 1'b0};
    vecs[4] = '{16'h6AAA, 8'h80, 1'b1};
    vecs[5] = '{16'h9249, 8'h49, 1'b0};
    vecs[6] = '{16'hC000, 8'h80, 1'b1};
    vecs[7] = '{16'h0003, 8'h01, 1'b1};

    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; strobe = 1'b0; mbit = 1'b0;
    sync = 1'b0; byte_count = 16'd0; bus.DATA_READY = 1'b0;
    repeat (3) tick();
    chk("rst_valid", bus.DATA_VALID, 1'b0);
    chk("rst_data", bus.DATA_OUT, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flags", {done, overrun, mfm_err}, 3'b000);
    rst_n = 1'b1;
    tick();

    // single-byte table; sync-word cells sent while ARMED must be ignored
    bus.DATA_READY = 1'b1;
    for (int v = 0; v < 8; v++) begin
      got_q.delete();
      do_arm(16'd1);
      chk($sformatf("v%0d_busy_armed", v), busy, 1'b1);
      if (v == 0) send_cells(MFM_SYNC_A1, 16);
      sync_pulse();
      send_cells(vecs[v].cells, 16);
      wait_bytes($sformatf("v%0d_nbytes", v), 1, 20);
      if (got_q.size() > 0) chk($sformatf("v%0d_byte", v), got_q[0], vecs[v].exp_byte);
      chk($sformatf("v%0d_done", v), done, 1'b1);
      chk($sformatf("v%0d_busy", v), busy, 1'b0);
      chk($sformatf("v%0d_err", v), mfm_err, vecs[v].exp_err);
    end

    // three bytes with BYTE_COUNT=3, then strobes after DONE decode nothing
    got_q.delete();
    do_arm(16'd3);
    send_cells(MFM_SYNC_C2, 16);
    sync_pulse();
    send_cells(enc(8'hA1, 1'b0), 16);
    send_cells(enc(8'hFE, 1'b1), 16);
    send_cells(enc(8'h00, 1'b0), 16);
    wait_bytes("t2_nbytes", 3, 20);
    if (got_q.size() == 3) begin
      chk("t2_b0", got_q[0], 8'hA1);
      chk("t2_b1", got_q[1], 8'hFE);
      chk("t2_b2", got_q[2], 8'h00);
    end
    chk("t2_done_busy", {done, busy}, 2'b10);
    send_cells(enc(8'h55, 1'b0), 16);
    repeat (4) tick();
    chk("t2_no_extra", got_q.size(), 3);

    // overrun: consumer stalled, six bytes into a four-entry FIFO
    got_q.delete();
    bus.DATA_READY = 1'b0;
    do_arm(16'd6);
    chk("t3_arm_clears_done", done, 1'b0);
    sync_pulse();
    for (int b = 1; b <= 6; b++) send_cells(enc(8'(b * 8'h11), 1'b0), 16);
    repeat (3) tick();
    chk("t3_flags", {done, overrun, busy}, 3'b110);
    chk("t3_head", {bus.DATA_VALID, bus.DATA_OUT}, {1'b1, 8'h11});
    bus.DATA_READY = 1'b1;
    repeat (20) tick();
    chk("t3_drained", got_q.size(), 4);
    if (got_q.size() == 4)
      for (int b = 0; b < 4; b++) chk($sformatf("t3_b%0d", b), got_q[b], 8'((b + 1) * 8'h11));
    chk("t3_empty", bus.DATA_VALID, 1'b0);

    // MFM violation stays sticky through DONE, cleared by the next ARM
    do_arm(16'd2);
    chk("t4_arm_clears_ovr", overrun, 1'b0);
    sync_pulse();
    send_cells(16'h6AAA, 16);
    send_cells(enc(8'h00, 1'b0), 16);
    repeat (3) tick();
    chk("t4_err_done", {mfm_err, done, busy}, 3'b110);
    do_arm(16'd2);
    chk("t4_err_cleared", {mfm_err, done, busy}, 3'b001);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_abort_idle", busy, 1'b0);

    // re-align: second sync five data bits into a byte
    got_q.delete();
    bus.DATA_READY = 1'b0;
    do_arm(16'd0);
    sync_pulse();
    send_cells(enc(8'hFF, 1'b0), 10);
    sync_pulse();
    send_cells(enc(8'h3C, 1'b1), 16);
    repeat (3) tick();
    chk("t5_head", {bus.DATA_VALID, bus.DATA_OUT}, {1'b1, 8'h3C});
    chk("t5_busy_err", {busy, mfm_err, done}, 3'b100);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t5_abort_flush", {bus.DATA_VALID, busy}, 2'b00);

    // reset mid-byte with FIFO occupied, then ABORT beating ARM
    do_arm(16'd0);
    sync_pulse();
    send_cells(enc(8'h5A, 1'b0), 16);
    send_cells(enc(8'hC3, 1'b0), 16);
    send_cells(enc(8'h77, 1'b1), 6);
    chk("t6_pre_valid", bus.DATA_VALID, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_out", {bus.DATA_VALID, bus.DATA_OUT}, 9'h000);
    chk("t6_rst_state", {busy, done, overrun, mfm_err}, 4'b0000);
    rst_n = 1'b1;
    tick();
    do_arm(16'd0);
    chk("t6_armed", busy, 1'b1);
    abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    chk("t6_abort_over_arm", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
